// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback-side bundle of the scoreboarded register file
interface regfile_sb_if #(parameter int XLEN = 32, parameter int NREGS = 32);
  localparam int AW = $clog2(NREGS);
  logic [AW-1:0] rs1, rs2, waddr, rsv_addr;
  logic [XLEN-1:0] rdata1, rdata2, wdata;
  logic rdy1, rdy2, we, rsv_en, clr_start, clr_busy;
  modport master (output rs1, rs2, we, waddr, wdata, rsv_en, rsv_addr, clr_start,
                  input rdata1, rdata2, rdy1, rdy2, clr_busy);
  modport slave (input rs1, rs2, we, waddr, wdata, rsv_en, rsv_addr, clr_start,
                 output rdata1, rdata2, rdy1, rdy2, clr_busy);
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with pending-write scoreboard, bypass and sequential clear
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam bit ZR = ZERO_REG != 0;
  localparam bit BP = BYPASS != 0;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic busy, z1, z2, byp1, byp2, wz, rz;
  assign busy = state == CLEAR;
  assign bus.clr_busy = busy;
  assign z1 = ZR && bus.rs1 == '0;
  assign z2 = ZR && bus.rs2 == '0;
  assign wz = ZR && bus.waddr == '0;
  assign rz = ZR && bus.rsv_addr == '0;
  assign byp1 = BP && bus.we && !busy && bus.waddr == bus.rs1 && !z1;
  assign byp2 = BP && bus.we && !busy && bus.waddr == bus.rs2 && !z2;
  assign bus.rdata1 = z1 ? '0 : byp1 ? bus.wdata : regs[bus.rs1];
  assign bus.rdata2 = z2 ? '0 : byp2 ? bus.wdata : regs[bus.rs2];
  assign bus.rdy1 = !pend[bus.rs1] || byp1;
  assign bus.rdy2 = !pend[bus.rs2] || byp2;
  // Later assignments win: reservation over writeback, clear over reservation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pend <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == IDLE) begin
      if (bus.we && !wz) regs[bus.waddr] <= bus.wdata;
      if (bus.we) pend[bus.waddr] <= 1'b0;
      if (bus.rsv_en && !rz) pend[bus.rsv_addr] <= 1'b1;
      if (bus.clr_start) begin
        state <= CLEAR;
        cnt <= '0;
        pend <= '0;
      end
    end else begin
      regs[cnt] <= '0;
      cnt <= cnt + 1'b1;
      if (cnt == AW'(NREGS - 1)) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed vector table plus clear/reset sequences, BYPASS=1 and BYPASS=0 instances
module tb_regfile_sb;
  localparam int AW = 5;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  regfile_sb_if #(.XLEN(32), .NREGS(N)) bus ();
  regfile_sb_if #(.XLEN(32), .NREGS(N)) nbus ();
  regfile_sb #(.XLEN(32), .NREGS(N), .ZERO_REG(1), .BYPASS(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  regfile_sb #(.XLEN(32), .NREGS(N), .ZERO_REG(1), .BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .bus(nbus));
  assign nbus.rs1 = bus.rs1;
  assign nbus.rs2 = bus.rs2;
  assign nbus.we = bus.we;
  assign nbus.waddr = bus.waddr;
  assign nbus.wdata = bus.wdata;
  assign nbus.rsv_en = bus.rsv_en;
  assign nbus.rsv_addr = bus.rsv_addr;
  assign nbus.clr_start = bus.clr_start;
  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [AW-1:0] waddr; logic [31:0] wdata;
    logic rsv_en; logic [AW-1:0] rsv_addr;
    logic [AW-1:0] rs1, rs2;
    logic [31:0] rd1, rd2; logic ry1, ry2;
    logic [31:0] nrd1, nrd2; logic ry1n, ry2n;
  } vec_t;
  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.we = 0; bus.waddr = '0; bus.wdata = '0;
    bus.rsv_en = 0; bus.rsv_addr = '0; bus.clr_start = 0;
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      bus.rs1 = AW'(i);
      bus.rs2 = AW'(N - 1 - i);
      #1;
      chk({tag, "_rdata1"}, bus.rdata1, 32'h0);
      chk({tag, "_rdata2"}, bus.rdata2, 32'h0);
      chk({tag, "_rdy1"}, {31'b0, bus.rdy1}, 32'h1);
      chk({tag, "_rdy2"}, {31'b0, bus.rdy2}, 32'h1);
    end
    chk({tag, "_busy"}, {31'b0, bus.clr_busy}, 32'h0);
  endtask

  initial begin
    int n;
    vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 1, 1, 0, 0, 1, 1};
    vt[1]  = '{0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1};
    vt[2]  = '{1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF, 1, 1};
    vt[4]  = '{0, 0, 0, 1, 7, 7, 5, 0, 32'hDEADBEEF, 1, 1, 0, 32'hDEADBEEF, 1, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 7, 5, 0, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 0, 1};
    vt[6]  = '{1, 7, 32'h77, 1, 7, 7, 7, 32'h77, 32'h77, 1, 1, 0, 0, 0, 0};
    vt[7]  = '{0, 0, 0, 0, 0, 7, 7, 32'h77, 32'h77, 0, 0, 32'h77, 32'h77, 0, 0};
    vt[8]  = '{1, 7, 32'h88, 0, 0, 7, 5, 32'h88, 32'hDEADBEEF, 1, 1, 32'h77, 32'hDEADBEEF, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 0, 7, 5, 32'h88, 32'hDEADBEEF, 1, 1, 32'h88, 32'hDEADBEEF, 1, 1};
    vt[10] = '{1, 10, 32'hA, 1, 9, 9, 10, 0, 32'hA, 1, 1, 0, 0, 1, 1};
    vt[11] = '{0, 0, 0, 0, 0, 9, 10, 0, 32'hA, 0, 1, 0, 32'hA, 0, 1};
    vt[12] = '{1, 9, 32'h99, 0, 0, 9, 9, 32'h99, 32'h99, 1, 1, 0, 0, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 9, 10, 32'h99, 32'hA, 1, 1, 32'h99, 32'hA, 1, 1};
    idle_in();
    bus.rs1 = '0; bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    all_zero("reset");
    for (int k = 0; k < 14; k++) begin
      bus.we = vt[k].we; bus.waddr = vt[k].waddr; bus.wdata = vt[k].wdata;
      bus.rsv_en = vt[k].rsv_en; bus.rsv_addr = vt[k].rsv_addr;
      bus.rs1 = vt[k].rs1; bus.rs2 = vt[k].rs2;
      #1;
      chk($sformatf("v%0d_rdata1", k), bus.rdata1, vt[k].rd1);
      chk($sformatf("v%0d_rdata2", k), bus.rdata2, vt[k].rd2);
      chk($sformatf("v%0d_rdy1", k), {31'b0, bus.rdy1}, {31'b0, vt[k].ry1});
      chk($sformatf("v%0d_rdy2", k), {31'b0, bus.rdy2}, {31'b0, vt[k].ry2});
      chk($sformatf("v%0d_nb_rdata1", k), nbus.rdata1, vt[k].nrd1);
      chk($sformatf("v%0d_nb_rdata2", k), nbus.rdata2, vt[k].nrd2);
      chk($sformatf("v%0d_nb_rdy1", k), {31'b0, nbus.rdy1}, {31'b0, vt[k].ry1n});
      chk($sformatf("v%0d_nb_rdy2", k), {31'b0, nbus.rdy2}, {31'b0, vt[k].ry2n});
      step();
    end
    idle_in();
    // Fill 1..31 with their index, then sweep-clear while hammering we/rsv_en
    for (int i = 1; i < N; i++) begin
      bus.we = 1; bus.waddr = AW'(i); bus.wdata = 32'(i);
      step();
    end
    idle_in();
    bus.rs1 = 5'd31; bus.rs2 = 5'd17;
    #1;
    chk("fill_r31", bus.rdata1, 32'd31);
    chk("fill_r17", bus.rdata2, 32'd17);
    bus.clr_start = 1; bus.rsv_en = 1; bus.rsv_addr = 5'd4;
    #1;
    chk("clr_start_busy", {31'b0, bus.clr_busy}, 32'h0);
    step();
    idle_in();
    bus.we = 1; bus.waddr = 5'd3; bus.wdata = 32'hFFFF;
    bus.rsv_en = 1; bus.rsv_addr = 5'd6;
    bus.rs1 = 5'd31;
    #1;
    n = 0;
    while (bus.clr_busy && n < 100) begin
      n++;
      if (n == 1) chk("clear_no_bypass", bus.rdata1, 32'd31);
      step();
    end
    chk("clear_cycles", 32'(n), 32'd32);
    idle_in();
    all_zero("after_clear");
    // Reset landing mid-clear
    bus.we = 1; bus.waddr = 5'd20; bus.wdata = 32'h55;
    bus.rsv_en = 1; bus.rsv_addr = 5'd21;
    step();
    idle_in();
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    repeat (9) step();
    bus.rs1 = 5'd20; bus.rs2 = 5'd21;
    #1;
    chk("clr10_busy", {31'b0, bus.clr_busy}, 32'h1);
    chk("clr10_r20", bus.rdata1, 32'h55);
    #1 rst = 1;
    #1;
    chk("rst_busy", {31'b0, bus.clr_busy}, 32'h0);
    chk("rst_r20", bus.rdata1, 32'h0);
    all_zero("mid_rst");
    @(negedge clk);
    rst = 0;
    step();
    bus.we = 1; bus.waddr = 5'd12; bus.wdata = 32'hC0DE;
    step();
    idle_in();
    bus.rs1 = 5'd12;
    #1;
    chk("post_rst_write", bus.rdata1, 32'hC0DE);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
